// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit beside the EX ALU.
// Iterative shift-add multiply and restoring divide; holds the pipeline until the result is out.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start_i; special div cases resolve here directly
//   CALC  | retiring UNROLL bits per cycle for N = XLEN/UNROLL cycles
//   FIX   | sign correction and low/high or quotient/remainder select
//   DONE  | done_o pulse with result_o/waddr_o, pipeline released
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      waddr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      waddr_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      waddr_q, waddr_d;
  logic            stall;

  // Operand decode at issue
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  always_comb begin
    is_div   = op_i[2];
    a_sgn    = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    b_sgn    = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    a_neg    = a_sgn & rs1_i[XLEN-1];
    b_neg    = b_sgn & rs2_i[XLEN-1];
    abs_a    = a_neg ? -rs1_i : rs1_i;
    abs_b    = b_neg ? -rs2_i : rs2_i;
    div_zero = is_div && (rs2_i == '0);
    div_ovf  = ((op_i == 3'd4) || (op_i == 3'd6)) &&
               (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    // REM/REMU (op_i[1]=1): rs1 on divide-by-zero, 0 on overflow.
    if (op_i[1])
      special_res = div_zero ? rs1_i : '0;
    else
      special_res = div_zero ? '1 : rs1_i;
  end

  // One CALC cycle: UNROLL shift-add or restoring-divide steps on {hi, lo}
  logic [XLEN-1:0] it_hi, it_lo;
  logic [XLEN:0]   sum, trial;

  always_comb begin
    it_hi = hi_q;
    it_lo = lo_q;
    sum   = '0;
    trial = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op_q[2]) begin
        sum   = {1'b0, it_hi} + (it_lo[0] ? {1'b0, opa_q} : '0);
        it_lo = {sum[0], it_lo[XLEN-1:1]};
        it_hi = sum[XLEN:1];
      end else begin
        trial = {it_hi, it_lo[XLEN-1]};
        it_lo = {it_lo[XLEN-2:0], 1'b0};
        if (trial >= {1'b0, opb_q}) begin
          trial    = trial - {1'b0, opb_q};
          it_lo[0] = 1'b1;
        end
        it_hi = trial[XLEN-1:0];
      end
    end
  end

  // Sign correction and result select
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = neg_rem_q ? -hi_q : hi_q;
    if (!op_q[2])
      fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else
      fix_res = op_q[1] ? rem_s : quo_s;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    result_d  = '0;
    waddr_d   = '0;
    stall     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          stall = 1'b1;
          op_d  = op_i;
          rd_d  = waddr_i;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = special_res;
            waddr_d  = waddr_i;
          end else begin
            state_d   = S_CALC;
            busy_d    = 1'b1;
            cnt_d     = CW'(N - 1);
            opa_d     = abs_a;
            opb_d     = abs_b;
            hi_d      = '0;
            lo_d      = is_div ? abs_a : abs_b;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      S_CALC: begin
        stall  = 1'b1;
        busy_d = 1'b1;
        hi_d   = it_hi;
        lo_d   = it_lo;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0)
          state_d = S_FIX;
      end
      S_FIX: begin
        stall    = 1'b1;
        state_d  = S_DONE;
        done_d   = 1'b1;
        result_d = fix_res;
        waddr_d  = rd_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush wins over everything, including a same-cycle issue.
    if (flush_i) begin
      state_d  = S_IDLE;
      stall    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = '0;
      waddr_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      waddr_q   <= waddr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign waddr_o     = waddr_q;
  assign stall_req_o = stall;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table plus flush/reset sequences.
// A second instance built with UNROLL=2 runs the same stimulus to check its shorter latency.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  waddr_i = '0;

  logic        busy_o, stall_req_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  waddr_o;
  logic        busy2, stall2, done2;
  logic [31:0] result2;
  logic [4:0]  waddr2;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .waddr_i(waddr_i), .flush_i(flush_i),
    .busy_o(busy_o), .stall_req_o(stall_req_o), .done_o(done_o),
    .result_o(result_o), .waddr_o(waddr_o)
  );

  ex_muldiv #(.XLEN(32), .UNROLL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .waddr_i(waddr_i), .flush_i(flush_i),
    .busy_o(busy2), .stall_req_o(stall2), .done_o(done2),
    .result_o(result2), .waddr_o(waddr2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller is #1 after a rising edge; that cycle is cycle 0 of the op.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_cyc,
                        input string name);
    int cyc, dc, dc2, exp2;
    exp2 = (exp_cyc == 1) ? 1 : 18;
    dc = -1;
    dc2 = -1;
    cyc = 0;
    start_i = 1'b1;
    op_i = op;
    rs1_i = a;
    rs2_i = b;
    waddr_i = rd;
    while (dc < 0 && cyc < 60) begin
      @(negedge clk);
      if (cyc == 0) check({name, " busy_c0"}, 32'(busy_o), 32'd0);
      check({name, " stall"}, 32'(stall_req_o), 32'(cyc < exp_cyc));
      if (done_o) begin
        dc = cyc;
        check({name, " result"}, result_o, exp);
        check({name, " waddr"}, 32'(waddr_o), 32'(rd));
      end
      if (done2 && dc2 < 0) begin
        dc2 = cyc;
        check({name, " result_u2"}, result2, exp);
        check({name, " waddr_u2"}, 32'(waddr2), 32'(rd));
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
      cyc++;
    end
    check({name, " done_cycle"}, 32'(dc), 32'(exp_cyc));
    check({name, " done_cycle_u2"}, 32'(dc2), 32'(exp2));
    @(negedge clk);
    check({name, " done_after"}, 32'(done_o), 32'd0);
    check({name, " result_after"}, result_o, 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int seen;
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         34};
    vecs[8]  = '{3'd5, 32'd100,       32'd0,         5'd9,  32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd100,       32'd0,         5'd10, 32'd100,       1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1};
    vecs[12] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 5'd13, 32'h2345_6780, 34};
    vecs[13] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0005, 5'd14, 32'hFFFF_FFFF, 34};
    vecs[14] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 34};
    vecs[15] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd16, 32'd1,         34};
    vecs[16] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         34};
    vecs[17] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 34};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset waddr", 32'(waddr_o), 32'd0);
    check("reset stall", 32'(stall_req_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].cyc,
             $sformatf("vec%0d", i));

    // Flush a DIV during cycle 10, restart in cycle 11.
    seen = 0;
    start_i = 1'b1;
    op_i = 3'd4;
    rs1_i = 32'd1000;
    rs2_i = 32'd3;
    waddr_i = 5'd20;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_o || done2) seen++;
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    if (done_o || done2) seen++;
    check("flush stall_drop", 32'(stall_req_o), 32'd0);
    check("flush no_done", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    run_op(3'd5, 32'd100, 32'd7, 5'd21, 32'd14, 34, "after_flush");

    // start together with flush in IDLE is not accepted.
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i = 3'd0;
    rs1_i = 32'd3;
    rs2_i = 32'd4;
    @(negedge clk);
    check("start_flush stall", 32'(stall_req_o), 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_o || done_o) seen++;
      @(posedge clk);
      #1;
    end
    check("start_flush ignored", 32'(seen), 32'd0);

    // Asynchronous reset mid-CALC.
    start_i = 1'b1;
    op_i = 3'd0;
    rs1_i = 32'd7;
    rs2_i = 32'hFFFF_FFFD;
    waddr_i = 5'd9;
    repeat (6) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    #1;
    check("pre_reset busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset busy", 32'(busy_o), 32'd0);
    check("async_reset stall", 32'(stall_req_o), 32'd0);
    check("async_reset done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset while the result is on the outputs.
    start_i = 1'b1;
    op_i = 3'd5;
    rs1_i = 32'd50;
    rs2_i = 32'd0;
    waddr_i = 5'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("pre_reset done", 32'(done_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset result", result_o, 32'd0);
    check("async_reset waddr", 32'(waddr_o), 32'd0);
    check("async_reset done2", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFEB, 34, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
